time_set_ctrl: RTL and testbench
================================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 100000000, clk cycles per one-second tick (legal range >= 2).
REQ-002 SHALL have parameter TIMEOUT_S, default 10, idle seconds in a set mode before an abort.
REQ-003 SHALL have port clk  in  1  single system clock, rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port btn_mode  in  1  debounced single-cycle pulse; advances the mode.
REQ-006 SHALL have port btn_inc  in  1  debounced single-cycle pulse; increments the field being edited.
REQ-007 SHALL have ports cur_hours_tens, cur_hours_units, cur_minutes_tens, cur_minutes_units  in  4 each  live BCD time from the counter.
REQ-008 SHALL have port tick_en  out  1  one-cycle count enable to the time counter.
REQ-009 SHALL have port load_en  out  1  one-cycle strobe: counter loads the load_* values and zeroes the seconds.
REQ-010 SHALL have ports load_hours_tens, load_hours_units, load_minutes_tens, load_minutes_units  out  4 each  BCD values to load.
REQ-011 SHALL have port mode  out  2  00 RUN, 01 SET_HOURS, 10 SET_MINUTES, 11 COMMIT.
REQ-012 SHALL have port blink  out  1  display blink phase for the edited field.

Function
REQ-013 SHALL implement the FSM RUN -> SET_HOURS -> SET_MINUTES -> COMMIT -> RUN; each transition out of RUN, SET_HOURS and SET_MINUTES occurs on btn_mode, and COMMIT lasts exactly one cycle.
REQ-014 SHALL capture the cur_* inputs into the edit registers in the same cycle that btn_mode moves the FSM from RUN to SET_HOURS.
REQ-015 SHALL keep a prescaler counting 0..CLK_DIV-1 and assert tick_en for one cycle when it wraps, only while in RUN.
REQ-016 SHALL hold the prescaler at 0 outside RUN, so the first tick after COMMIT or an abort occurs CLK_DIV cycles later.
REQ-017 SHALL, on btn_inc in SET_HOURS, increment the hours in BCD 00..23, with 23 wrapping to 00 and x9 carrying to (x+1)0.
REQ-018 SHALL, on btn_inc in SET_MINUTES, increment the minutes in BCD 00..59, with 59 wrapping to 00; the hours are unaffected.
REQ-019 SHALL ignore btn_inc in RUN and COMMIT.
REQ-020 SHALL give btn_mode priority when btn_mode and btn_inc are asserted in the same cycle: the mode advances and the increment is discarded.
REQ-021 SHALL assert load_en only in COMMIT, with load_* driven from the edit registers; load_* SHALL track the edit registers at all times.
REQ-022 SHALL keep a set-mode idle counter that counts internal one-second periods (CLK_DIV cycles) and clears on any btn_mode or btn_inc.
REQ-023 SHALL, when the idle counter reaches TIMEOUT_S in a set mode, return to RUN without asserting load_en.
REQ-024 SHALL toggle blink every CLK_DIV/2 cycles while in a set mode, and hold blink at 0 in RUN and COMMIT.
REQ-025 SHALL drive the mode, tick_en, load_en and blink outputs from registers with no combinational input-to-output path.

Reset
REQ-026 SHALL, on reset assertion, immediately set the FSM to RUN, the prescaler, idle counter and edit registers to 0, and tick_en, load_en and blink to 0.
REQ-027 SHALL, when reset is asserted mid-edit, discard the edit with no load_en pulse.
REQ-028 SHALL produce the first tick_en CLK_DIV cycles after reset deassertion.

Structure
REQ-029 SHALL take the mode encoding enum and the BCD limits (23, 59) from a shared clock package.
REQ-030 SHALL instantiate one sub-module, bcd_wrap_inc, a two-digit BCD incrementer with a max-value input, used for both hours and minutes.

Verification (CLK_DIV=4, TIMEOUT_S=3)
REQ-031 SHALL verify: release reset, hold in RUN -> tick_en pulses on cycles 4, 8, 12; load_en stays 0.
REQ-032 SHALL verify: cur=21:58, btn_mode, then 3x btn_inc -> load_hours = 00 (21->22->23->00).
REQ-033 SHALL verify: cur=21:58, btn_mode, btn_mode, 2x btn_inc, btn_mode -> one load_en with 21:00; mode back to 00; next tick_en 4 cycles later.
REQ-034 SHALL verify: btn_mode and btn_inc in the same cycle in SET_HOURS -> mode=10 and hours unchanged.
REQ-035 SHALL verify: enter SET_HOURS, no buttons for 12 cycles -> mode=00 and no load_en.
REQ-036 SHALL verify: reset asserted in SET_MINUTES -> outputs 0 and mode=00 in the same cycle; no load_en.

Source files
------------

// File: rtl/time_set_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : time_set_ctrl_pkg
//  Description : Shared clock-setting definitions: the controller mode
//                encoding and the BCD upper limits for hours and minutes.
//  Revision    : 1.0 - initial release
// ============================================================================
package time_set_ctrl_pkg;

   // Encoding is visible on the mode output, so the values are fixed.
   typedef enum logic [1:0] {
      MODE_RUN         = 2'b00,
      MODE_SET_HOURS   = 2'b01,
      MODE_SET_MINUTES = 2'b10,
      MODE_COMMIT      = 2'b11
   } mode_e;

   // Two-digit BCD limits; a field at its limit wraps back to 00.
   localparam logic [7:0] c_hours_max   = 8'h23;
   localparam logic [7:0] c_minutes_max = 8'h59;

   function automatic logic is_set_mode(input mode_e m);
      return (m == MODE_SET_HOURS) || (m == MODE_SET_MINUTES);
   endfunction

endpackage
`default_nettype wire

// File: rtl/time_set_ctrl_bcd_wrap_inc.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_wrap_inc
//  Description : Combinational two-digit BCD incrementer with wrap-around.
//                A value at (or beyond) max_val wraps to 00; a units digit
//                of 9 carries into the tens digit.
//  Ports       : tens, units        - current BCD digits
//                max_val            - packed BCD limit {tens, units}
//                next_tens/units    - incremented BCD digits
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_wrap_inc (
   input  logic [3:0] tens,
   input  logic [3:0] units,
   input  logic [7:0] max_val,
   output logic [3:0] next_tens,
   output logic [3:0] next_units
);

   always_comb begin
      next_tens  = tens;
      next_units = units + 4'd1;
      // BCD ordering matches binary ordering, so a packed compare is valid
      // and also recovers cleanly from an out-of-range loaded value.
      if ({tens, units} >= max_val) begin
         next_tens  = 4'd0;
         next_units = 4'd0;
      end else if (units >= 4'd9) begin
         next_tens  = tens + 4'd1;
         next_units = 4'd0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : time_set_ctrl
//  Description : Clock time-setting controller. Generates the one-second
//                count enable in RUN, lets the user edit hours then minutes
//                with two push buttons, loads the edited time on COMMIT and
//                abandons the edit after TIMEOUT_S idle seconds.
//  Ports       : clk, reset (async, active high)
//                btn_mode, btn_inc       - single-cycle button pulses
//                cur_*                   - live BCD time from the counter
//                tick_en                 - one-second count enable
//                load_en, load_*         - load strobe and BCD load value
//                mode                    - 00 RUN, 01 SET_H, 10 SET_M, 11 COMMIT
//                blink                   - blink phase for the edited field
//  Revision    : 1.0 - initial release
// ============================================================================
module time_set_ctrl
   import time_set_ctrl_pkg::*;
#(
   parameter int CLK_DIV   = 100000000,
   parameter int TIMEOUT_S = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [3:0] cur_hours_tens,
   input  logic [3:0] cur_hours_units,
   input  logic [3:0] cur_minutes_tens,
   input  logic [3:0] cur_minutes_units,
   output logic       tick_en,
   output logic       load_en,
   output logic [3:0] load_hours_tens,
   output logic [3:0] load_hours_units,
   output logic [3:0] load_minutes_tens,
   output logic [3:0] load_minutes_units,
   output logic [1:0] mode,
   output logic       blink
);

   localparam int c_pw = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int c_sw = $clog2(TIMEOUT_S + 1);
   localparam logic [c_pw-1:0] c_div_last    = c_pw'(CLK_DIV - 1);
   localparam logic [c_pw-1:0] c_div_half_m1 = c_pw'(CLK_DIV / 2 - 1);
   localparam logic [c_sw-1:0] c_secs_last   = c_sw'(TIMEOUT_S - 1);

   mode_e           r_state;
   mode_e           w_next_state;
   logic [c_pw-1:0] r_presc;
   logic [c_pw-1:0] r_idle_div;
   logic [c_sw-1:0] r_idle_secs;
   logic            r_tick_en;
   logic            r_load_en;
   logic            r_blink;
   logic [3:0]      r_hrs_tens, r_hrs_units, r_min_tens, r_min_units;

   logic            w_any_btn;
   logic            w_set_mode;
   logic            w_timeout;
   logic            w_inc_min;
   logic [3:0]      w_inc_tens_in, w_inc_units_in;
   logic [3:0]      w_inc_tens_out, w_inc_units_out;
   logic [7:0]      w_inc_max;

   assign w_any_btn  = btn_mode | btn_inc;
   assign w_set_mode = is_set_mode(r_state);
   // Timeout fires on the last cycle of the final idle second, so the FSM
   // is back in RUN exactly TIMEOUT_S*CLK_DIV cycles after the last button.
   assign w_timeout  = w_set_mode && !w_any_btn &&
                       (r_idle_div == c_div_last) && (r_idle_secs == c_secs_last);

   // One shared incrementer; the field being edited selects its operands.
   assign w_inc_min      = (r_state == MODE_SET_MINUTES);
   assign w_inc_tens_in  = w_inc_min ? r_min_tens  : r_hrs_tens;
   assign w_inc_units_in = w_inc_min ? r_min_units : r_hrs_units;
   assign w_inc_max      = w_inc_min ? c_minutes_max : c_hours_max;

   bcd_wrap_inc u_bcd_wrap_inc (
      .tens       (w_inc_tens_in),
      .units      (w_inc_units_in),
      .max_val    (w_inc_max),
      .next_tens  (w_inc_tens_out),
      .next_units (w_inc_units_out)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= MODE_RUN;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         MODE_RUN: begin
            if (btn_mode) w_next_state = MODE_SET_HOURS;
         end
         MODE_SET_HOURS: begin
            if (btn_mode)       w_next_state = MODE_SET_MINUTES;
            else if (w_timeout) w_next_state = MODE_RUN;
         end
         MODE_SET_MINUTES: begin
            if (btn_mode)       w_next_state = MODE_COMMIT;
            else if (w_timeout) w_next_state = MODE_RUN;
         end
         default: w_next_state = MODE_RUN;   // COMMIT lasts one cycle
      endcase
   end

   // ------------------------------------------------- run-mode prescaler
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_presc   <= '0;
         r_tick_en <= 1'b0;
      end else if (r_state != MODE_RUN) begin
         r_presc   <= '0;
         r_tick_en <= 1'b0;
      end else if (r_presc == c_div_last) begin
         r_presc   <= '0;
         r_tick_en <= 1'b1;
      end else begin
         r_presc   <= r_presc + 1'b1;
         r_tick_en <= 1'b0;
      end
   end

   // ------------------------------------ set-mode idle timer and blink
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idle_div  <= '0;
         r_idle_secs <= '0;
      end else if (!w_set_mode || w_any_btn) begin
         r_idle_div  <= '0;
         r_idle_secs <= '0;
      end else if (r_idle_div == c_div_last) begin
         r_idle_div  <= '0;
         r_idle_secs <= r_idle_secs + 1'b1;
      end else begin
         r_idle_div  <= r_idle_div + 1'b1;
      end
   end

   // Blink reuses the idle sub-second counter: it toggles at the half and
   // at the end of each second, giving a CLK_DIV/2 half-period.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_blink <= 1'b0;
      end else if (!is_set_mode(w_next_state)) begin
         r_blink <= 1'b0;
      end else if (w_set_mode && !w_any_btn &&
                   ((r_idle_div == c_div_half_m1) || (r_idle_div == c_div_last))) begin
         r_blink <= ~r_blink;
      end
   end

   // ------------------------------------------------ edit registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hrs_tens  <= 4'd0;
         r_hrs_units <= 4'd0;
         r_min_tens  <= 4'd0;
         r_min_units <= 4'd0;
      end else if ((r_state == MODE_RUN) && btn_mode) begin
         r_hrs_tens  <= cur_hours_tens;
         r_hrs_units <= cur_hours_units;
         r_min_tens  <= cur_minutes_tens;
         r_min_units <= cur_minutes_units;
      end else if ((r_state == MODE_SET_HOURS) && btn_inc && !btn_mode) begin
         r_hrs_tens  <= w_inc_tens_out;
         r_hrs_units <= w_inc_units_out;
      end else if ((r_state == MODE_SET_MINUTES) && btn_inc && !btn_mode) begin
         r_min_tens  <= w_inc_tens_out;
         r_min_units <= w_inc_units_out;
      end
   end

   // load_en is registered from the next state so it is high for exactly
   // the COMMIT cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_load_en <= 1'b0;
      else       r_load_en <= (w_next_state == MODE_COMMIT);
   end

   assign mode               = r_state;
   assign tick_en            = r_tick_en;
   assign load_en            = r_load_en;
   assign blink              = r_blink;
   assign load_hours_tens    = r_hrs_tens;
   assign load_hours_units   = r_hrs_units;
   assign load_minutes_tens  = r_min_tens;
   assign load_minutes_units = r_min_units;

endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_time_set_ctrl
//  Description : Directed self-checking bench for time_set_ctrl with
//                CLK_DIV=4 and TIMEOUT_S=3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_time_set_ctrl;

   logic       clk;
   logic       reset;
   logic       btn_mode, btn_inc;
   logic [3:0] cur_hours_tens, cur_hours_units, cur_minutes_tens, cur_minutes_units;
   logic       tick_en, load_en, blink;
   logic [3:0] load_hours_tens, load_hours_units, load_minutes_tens, load_minutes_units;
   logic [1:0] mode;
   logic [15:0] w_load;

   int n_checks = 0;
   int n_errors = 0;

   time_set_ctrl #(
      .CLK_DIV   (4),
      .TIMEOUT_S (3)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .btn_mode           (btn_mode),
      .btn_inc            (btn_inc),
      .cur_hours_tens     (cur_hours_tens),
      .cur_hours_units    (cur_hours_units),
      .cur_minutes_tens   (cur_minutes_tens),
      .cur_minutes_units  (cur_minutes_units),
      .tick_en            (tick_en),
      .load_en            (load_en),
      .load_hours_tens    (load_hours_tens),
      .load_hours_units   (load_hours_units),
      .load_minutes_tens  (load_minutes_tens),
      .load_minutes_units (load_minutes_units),
      .mode               (mode),
      .blink              (blink)
   );

   assign w_load = {load_hours_tens, load_hours_units, load_minutes_tens, load_minutes_units};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [15:0] actual,
                              input logic [15:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_mode();
      btn_mode = 1'b1;
      step();
      btn_mode = 1'b0;
   endtask

   task automatic pulse_inc();
      btn_inc = 1'b1;
      step();
      btn_inc = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset             = 1'b1;
      btn_mode          = 1'b0;
      btn_inc           = 1'b0;
      cur_hours_tens    = 4'd2;
      cur_hours_units   = 4'd1;
      cur_minutes_tens  = 4'd5;
      cur_minutes_units = 4'd8;

      // Reset state
      #2;
      check_value("rst_mode",   16'(mode),    16'h0);
      check_value("rst_tick",   16'(tick_en), 16'h0);
      check_value("rst_load_en",16'(load_en), 16'h0);
      check_value("rst_blink",  16'(blink),   16'h0);
      check_value("rst_load",   w_load,       16'h0000);
      step();
      step();
      reset = 1'b0;

      // RUN: tick_en on cycles 4, 8, 12 after reset release
      for (int n = 1; n <= 12; n++) begin
         step();
         check_value($sformatf("run_tick_c%0d", n), 16'(tick_en), 16'((n % 4) == 0));
         check_value($sformatf("run_load_en_c%0d", n), 16'(load_en), 16'h0);
      end

      // Hours increment with wrap: 21 -> 22 -> 23 -> 00
      pulse_mode();
      check_value("seth_mode", 16'(mode), 16'h1);
      check_value("seth_capture", w_load, 16'h2158);
      pulse_inc();
      check_value("hrs_22", w_load, 16'h2258);
      pulse_inc();
      check_value("hrs_23", w_load, 16'h2358);
      pulse_inc();
      check_value("hrs_00", w_load, 16'h0058);
      pulse_mode();
      check_value("setm_mode", 16'(mode), 16'h2);
      pulse_mode();
      check_value("commit1_mode", 16'(mode), 16'h3);
      check_value("commit1_load_en", 16'(load_en), 16'h1);
      check_value("commit1_load", w_load, 16'h0058);
      step();
      check_value("after1_mode", 16'(mode), 16'h0);
      check_value("after1_load_en", 16'(load_en), 16'h0);

      // Simultaneous buttons in SET_HOURS, then minute wrap and commit
      pulse_mode();
      check_value("seth2_capture", w_load, 16'h2158);
      btn_mode = 1'b1;
      btn_inc  = 1'b1;
      step();
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      check_value("both_mode", 16'(mode), 16'h2);
      check_value("both_hours_kept", w_load, 16'h2158);
      pulse_inc();
      check_value("min_59", w_load, 16'h2159);
      pulse_inc();
      check_value("min_00", w_load, 16'h2100);
      pulse_mode();
      check_value("commit2_mode", 16'(mode), 16'h3);
      check_value("commit2_load_en", 16'(load_en), 16'h1);
      check_value("commit2_load", w_load, 16'h2100);
      step();
      check_value("after2_mode", 16'(mode), 16'h0);
      check_value("after2_load_en", 16'(load_en), 16'h0);
      for (int k = 1; k <= 4; k++) begin
         step();
         check_value($sformatf("post_commit_tick_k%0d", k), 16'(tick_en), 16'(k == 4));
         check_value($sformatf("post_commit_load_en_k%0d", k), 16'(load_en), 16'h0);
      end

      // Idle timeout in SET_HOURS after 12 cycles, with blink phase
      pulse_mode();
      check_value("to_enter_mode", 16'(mode), 16'h1);
      for (int n = 1; n <= 12; n++) begin
         step();
         check_value($sformatf("to_mode_c%0d", n), 16'(mode), (n < 12) ? 16'h1 : 16'h0);
         check_value($sformatf("to_blink_c%0d", n), 16'(blink),
                     (n < 12) ? 16'((n >> 1) & 1) : 16'h0);
         check_value($sformatf("to_load_en_c%0d", n), 16'(load_en), 16'h0);
      end

      // Reset asserted in SET_MINUTES discards the edit immediately
      pulse_mode();
      pulse_mode();
      check_value("rm_mode", 16'(mode), 16'h2);
      pulse_inc();
      check_value("rm_min_59", w_load, 16'h2159);
      step();
      step();
      check_value("rm_blink_on", 16'(blink), 16'h1);
      #3;
      reset = 1'b1;
      #1;
      check_value("rm_mode_rst", 16'(mode), 16'h0);
      check_value("rm_blink_rst", 16'(blink), 16'h0);
      check_value("rm_load_en_rst", 16'(load_en), 16'h0);
      check_value("rm_tick_rst", 16'(tick_en), 16'h0);
      check_value("rm_load_rst", w_load, 16'h0000);
      step();
      reset = 1'b0;
      for (int n = 1; n <= 3; n++) begin
         step();
         check_value($sformatf("rm_post_load_en_c%0d", n), 16'(load_en), 16'h0);
         check_value($sformatf("rm_post_mode_c%0d", n), 16'(mode), 16'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
